aes128_ctr_core: RTL and testbench
==================================

# aes128_ctr_core

Iterative AES-128 encryption engine with a compile-time round-unroll factor and two run-time modes, ECB and CTR. It adds an output-hold handshake so the consumer can apply back-pressure. It sits between the host data path and the cipher output stage. It is built from the team's existing SubBytes and MixColumns primitives, and the round key is expanded on the fly.

## Interface
Parameters:
- RPC, 1, AES rounds computed per clock. Legal values are 1, 2 and 5; any other value is an elaboration error.
- CTR_W, 32, number of low-order counter bits incremented in CTR mode (1..128).

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Key  in  128  cipher key, sampled on key load.
- Iv  in  128  initial counter block, sampled on key load (CTR mode).
- Mode  in  1  0 = ECB, 1 = CTR; sampled on key load.
- Krin  in  1  key/mode/IV load strobe.
- Din  in  128  plaintext block.
- Drin  in  1  Din valid.
- Dack  in  1  consumer accepts Dout.
- Dout  out  128  ciphertext block.
- Drout  out  1  Dout valid; held until Dack.
- BSY  out  1  block in flight or awaiting Dack; Din is not accepted while high.

## Operation
- Reset state:
  - FSM is IDLE.
  - Dout = 0, Drout = 0, BSY = 0.
  - Key register, counter register, payload register and Mode register are all 0. A zero key is a defined, usable key.
- FSM states: IDLE, RUN, DONE.
- Key load (IDLE only, Krin = 1):
  - K0 <= Key, Ctr <= Iv, ModeR <= Mode.
  - Krin is ignored in RUN and DONE.
- Acceptance (IDLE, Drin = 1, Krin = 0):
  - If Krin and Drin are both high, the key load wins and the data is not accepted.
  - On acceptance the block moves to RUN and sets round index r = 1 and running key Kr <= K0.
  - ECB: S <= Din ^ K0.
  - CTR: S <= Ctr ^ K0 and P <= Din. Ctr[CTR_W-1:0] increments modulo 2^CTR_W; Ctr[127:CTR_W] is unchanged.
- RUN: each cycle applies RPC chained rounds combinationally.
  - Each round is SubBytes, ShiftRows, MixColumns (MixColumns skipped in round 10), then AddRoundKey with the next expanded key.
  - Key expansion chains per round with rcon 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - S, Kr and r register once per cycle; r advances by RPC.
- Completion (the cycle that computes round 10):
  - Dout <= S_final (ECB) or S_final ^ P (CTR).
  - Drout <= 1 and the FSM moves to DONE.
- DONE:
  - Dout and Drout are held stable while Dack = 0.
  - When Dack = 1: Drout <= 0 and BSY <= 0, and the FSM returns to IDLE. Dout keeps its last value.
- BSY = 1 throughout RUN and DONE.
- Reset asserted mid-operation aborts the block immediately (asynchronously). The loaded key and counter are cleared, and the block must be reloaded.

## Timing
- Acceptance edge T0.
- Rounds occupy N = 10/RPC RUN cycles (N = 10, 5 or 2). Dout and Drout are valid after edge T0+N.
- The earliest following acceptance is at edge T0+N+2: Dack is high at T0+N+1, BSY drops at T0+N+1, and Drin is sampled at T0+N+2.
- Peak throughput is one block per N+2 cycles.
- Key load takes 1 cycle; data may be accepted on the very next edge.
- Dack is ignored outside DONE. Drin and Krin are ignored while BSY = 1.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- ECB, RPC = 1, key 000102030405060708090a0b0c0d0e0f, Din 00112233445566778899aabbccddeeff, Dack tied 1 -> Dout 69c4e0d86a7b0430d8cdb78070b4c55a. Drout rises exactly 10 cycles after acceptance.
- ECB, RPC = 2 and RPC = 5, key 2b7e151628aed2a6abf7158809cf4f3c, Din 3243f6a8885a308d313198a2e0370734 -> Dout 3925841d02dc09fbdc118597196a0b32. Latency is 5 and 2 cycles respectively.
- CTR, key 2b7e151628aed2a6abf7158809cf4f3c, Iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff:
  - block 1, Din 6bc1bee22e409f96e93d7e117393172a -> 874d6191b620e3261bef6864990db6ce;
  - block 2, Din ae2d8a571e03ac9c9eb76fac45af8e51 -> 9806f66b7970fdff8617187bb9fffdff.
- Counter wrap, CTR_W = 32, Iv 00000000000000000000000affffffff -> after one block, Ctr = 000000000000000000000000a00000000 is wrong; the required value is 00000000000000000000000a00000000 (only the low 32 bits wrap to 00000000, the upper bits keep 0000000a). Simultaneous Krin and Drin in IDLE -> key loaded, no block accepted, BSY stays 0.
- Back-pressure: hold Dack = 0 for 5 cycles in DONE -> Dout and Drout stable; a Drin pulse is ignored; BSY = 1. Assert Reset in the 3rd RUN cycle -> Dout = 0, Drout = 0, BSY = 0 immediately, and the FSM is IDLE.

Source files
------------

// File: rtl/aes128_ctr_core.sv
// Iterative AES-128 encryptor (ECB / CTR) with RPC rounds per clock,
// on-the-fly key expansion and a held-until-acknowledged output register.
module aes128_ctr_core #(
    parameter int RPC   = 1,
    parameter int CTR_W = 32
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic [127:0] Key,
    input  logic [127:0] Iv,
    input  logic         Mode,
    input  logic         Krin,
    input  logic [127:0] Din,
    input  logic         Drin,
    input  logic         Dack,
    output logic [127:0] Dout,
    output logic         Drout,
    output logic         BSY
);

    generate
        if (!(RPC == 1 || RPC == 2 || RPC == 5)) begin : g_bad_rpc
            $error("aes128_ctr_core: RPC must be 1, 2 or 5");
        end
        if (CTR_W < 1 || CTR_W > 128) begin : g_bad_ctr_w
            $error("aes128_ctr_core: CTR_W must be in 1..128");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]   RPC_STEP = 4'(RPC);
    localparam logic [3:0]   LAST_R   = 4'(11 - RPC);
    localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx  = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rn);
        logic [7:0] rc;
        case (rn)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte i of the block sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] sb, sr, mc;
        for (int i = 0; i < 16; i++) begin
            sb[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8*(4*c + r) -: 8] = sb[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
        end
        return (last ? sr : mc) ^ rk;
    endfunction

    state_t       r_state, w_state_nxt;
    logic [127:0] r_k0, w_k0_nxt;
    logic [127:0] r_ctr, w_ctr_nxt;
    logic         r_mode, w_mode_nxt;
    logic [127:0] r_s, w_s_nxt;
    logic [127:0] r_kr, w_kr_nxt;
    logic [127:0] r_p, w_p_nxt;
    logic [3:0]   r_round, w_round_nxt;
    logic [127:0] r_dout, w_dout_nxt;
    logic         r_drout, w_drout_nxt;
    logic         r_bsy, w_bsy_nxt;
    logic [127:0] w_ctr_inc;

    logic [127:0] w_s [RPC+1];
    logic [127:0] w_k [RPC+1];

    assign w_s[0]    = r_s;
    assign w_k[0]    = r_kr;
    assign w_ctr_inc = (r_ctr & ~CTR_MASK) | ((r_ctr + 128'd1) & CTR_MASK);

    genvar g;
    generate
        for (g = 0; g < RPC; g++) begin : g_round
            logic [3:0] w_rn;
            assign w_rn       = r_round + 4'(g);
            assign w_k[g + 1] = key_expand(w_k[g], rcon(w_rn));
            assign w_s[g + 1] = aes_round(w_s[g], w_k[g + 1], (w_rn == 4'd10));
        end
    endgenerate

    // Next-state and next-register values for the whole engine.
    always_comb begin
        w_state_nxt = r_state;
        w_k0_nxt    = r_k0;
        w_ctr_nxt   = r_ctr;
        w_mode_nxt  = r_mode;
        w_s_nxt     = r_s;
        w_kr_nxt    = r_kr;
        w_p_nxt     = r_p;
        w_round_nxt = r_round;
        w_dout_nxt  = r_dout;
        w_drout_nxt = r_drout;
        w_bsy_nxt   = r_bsy;
        case (r_state)
            IDLE: begin
                if (Krin) begin
                    w_k0_nxt   = Key;
                    w_ctr_nxt  = Iv;
                    w_mode_nxt = Mode;
                end else if (Drin) begin
                    w_state_nxt = RUN;
                    w_bsy_nxt   = 1'b1;
                    w_round_nxt = 4'd1;
                    w_kr_nxt    = r_k0;
                    if (r_mode) begin
                        w_s_nxt   = r_ctr ^ r_k0;
                        w_p_nxt   = Din;
                        w_ctr_nxt = w_ctr_inc;
                    end else begin
                        w_s_nxt = Din ^ r_k0;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_s_nxt     = w_s[RPC];
                w_kr_nxt    = w_k[RPC];
                w_round_nxt = r_round + RPC_STEP;
                if (r_round == LAST_R) begin
                    w_dout_nxt  = r_mode ? (w_s[RPC] ^ r_p) : w_s[RPC];
                    w_drout_nxt = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (Dack) begin
                    w_drout_nxt = 1'b0;
                    w_bsy_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_drout_nxt = 1'b0;
                w_bsy_nxt   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key, counter, round datapath and output registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_k0    <= 128'd0;
            r_ctr   <= 128'd0;
            r_mode  <= 1'b0;
            r_s     <= 128'd0;
            r_kr    <= 128'd0;
            r_p     <= 128'd0;
            r_round <= 4'd0;
            r_dout  <= 128'd0;
            r_drout <= 1'b0;
            r_bsy   <= 1'b0;
        end else begin
            r_k0    <= w_k0_nxt;
            r_ctr   <= w_ctr_nxt;
            r_mode  <= w_mode_nxt;
            r_s     <= w_s_nxt;
            r_kr    <= w_kr_nxt;
            r_p     <= w_p_nxt;
            r_round <= w_round_nxt;
            r_dout  <= w_dout_nxt;
            r_drout <= w_drout_nxt;
            r_bsy   <= w_bsy_nxt;
        end
    end

    assign Dout  = r_dout;
    assign Drout = r_drout;
    assign BSY   = r_bsy;

endmodule

// File: tb/tb_aes128_ctr_core.sv
// Directed bench for aes128_ctr_core: three instances (RPC 1, 2, 5) share stimulus
// and are checked against published AES-128 ECB and CTR vectors.
module tb_aes128_ctr_core;

    localparam logic [127:0] K_A    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_A    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_A    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] IV_CTR = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] P_C1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C_C1   = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] P_C2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C_C2   = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] C_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [127:0] Key, Iv, Din;
    logic         Mode, Krin, Drin, Dack;
    logic [127:0] dout1, dout2, dout5;
    logic         drout1, drout2, drout5;
    logic         bsy1, bsy2, bsy5;
    int           n_pass  = 0;
    int           n_total = 0;

    always #5 CLK = ~CLK;

    aes128_ctr_core #(.RPC(1), .CTR_W(32)) u1 (
        .CLK(CLK), .Reset(Reset), .Key(Key), .Iv(Iv), .Mode(Mode), .Krin(Krin),
        .Din(Din), .Drin(Drin), .Dack(Dack), .Dout(dout1), .Drout(drout1), .BSY(bsy1));
    aes128_ctr_core #(.RPC(2), .CTR_W(32)) u2 (
        .CLK(CLK), .Reset(Reset), .Key(Key), .Iv(Iv), .Mode(Mode), .Krin(Krin),
        .Din(Din), .Drin(Drin), .Dack(Dack), .Dout(dout2), .Drout(drout2), .BSY(bsy2));
    aes128_ctr_core #(.RPC(5), .CTR_W(32)) u5 (
        .CLK(CLK), .Reset(Reset), .Key(Key), .Iv(Iv), .Mode(Mode), .Krin(Krin),
        .Din(Din), .Drin(Drin), .Dack(Dack), .Dout(dout5), .Drout(drout5), .BSY(bsy5));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, input logic [127:0] iv, input logic m);
        Key  = k;
        Iv   = iv;
        Mode = m;
        Krin = 1'b1;
        tick();
        Krin = 1'b0;
    endtask

    // One block with Dack high; latency 0 means Drout never rose within the budget.
    task automatic run_block(input logic [127:0] d,
                             output logic [127:0] o1, output logic [127:0] o2,
                             output logic [127:0] o5,
                             output int l1, output int l2, output int l5);
        l1 = 0; l2 = 0; l5 = 0;
        o1 = 128'd0; o2 = 128'd0; o5 = 128'd0;
        Din  = d;
        Drin = 1'b1;
        tick();
        Drin = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (drout1 && l1 == 0) begin l1 = n; o1 = dout1; end
            if (drout2 && l2 == 0) begin l2 = n; o2 = dout2; end
            if (drout5 && l5 == 0) begin l5 = n; o5 = dout5; end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        n_total++; if (dout1 !== 128'd0) $display("FAIL reset_dout: got %h want 0", dout1); else n_pass++;
        n_total++; if ({drout1, bsy1, drout5, bsy5} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {drout1, bsy1, drout5, bsy5}); else n_pass++;
        n_total++; if (u1.r_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", u1.r_state); else n_pass++;
        n_total++; if ({u1.r_k0, u1.r_ctr} !== 256'd0) $display("FAIL reset_key_ctr: got %h want 0", {u1.r_k0, u1.r_ctr}); else n_pass++;
        #2 Reset = 1'b0;
        tick();
    endtask

    task automatic test_ecb;
        logic [127:0] o1, o2, o5, k, p, c;
        int l1, l2, l5;
        Dack = 1'b1;
        for (int v = 0; v < 2; v++) begin
            k = (v == 0) ? K_A : K_B;
            p = (v == 0) ? P_A : P_B;
            c = (v == 0) ? C_A : C_B;
            load_key(k, 128'd0, 1'b0);
            run_block(p, o1, o2, o5, l1, l2, l5);
            n_total++; if (o1 !== c) $display("FAIL ecb%0d_rpc1: got %h want %h", v, o1, c); else n_pass++;
            n_total++; if (o2 !== c) $display("FAIL ecb%0d_rpc2: got %h want %h", v, o2, c); else n_pass++;
            n_total++; if (o5 !== c) $display("FAIL ecb%0d_rpc5: got %h want %h", v, o5, c); else n_pass++;
            n_total++; if (l1 !== 10) $display("FAIL ecb%0d_lat_rpc1: got %0d want 10", v, l1); else n_pass++;
            n_total++; if (l2 !== 5) $display("FAIL ecb%0d_lat_rpc2: got %0d want 5", v, l2); else n_pass++;
            n_total++; if (l5 !== 2) $display("FAIL ecb%0d_lat_rpc5: got %0d want 2", v, l5); else n_pass++;
        end
    endtask

    task automatic test_ctr;
        logic [127:0] o1, o2, o5;
        int l1, l2, l5;
        Dack = 1'b1;
        load_key(K_B, IV_CTR, 1'b1);
        run_block(P_C1, o1, o2, o5, l1, l2, l5);
        n_total++; if (o1 !== C_C1) $display("FAIL ctr1_rpc1: got %h want %h", o1, C_C1); else n_pass++;
        n_total++; if (o5 !== C_C1) $display("FAIL ctr1_rpc5: got %h want %h", o5, C_C1); else n_pass++;
        run_block(P_C2, o1, o2, o5, l1, l2, l5);
        n_total++; if (o1 !== C_C2) $display("FAIL ctr2_rpc1: got %h want %h", o1, C_C2); else n_pass++;
        n_total++; if (o2 !== C_C2) $display("FAIL ctr2_rpc2: got %h want %h", o2, C_C2); else n_pass++;
        n_total++; if (u1.r_ctr !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01)
            $display("FAIL ctr_after2: got %h want f0f1f2f3f4f5f6f7f8f9fafbfcfdff01", u1.r_ctr); else n_pass++;
    endtask

    task automatic test_ctr_wrap;
        logic [127:0] o1, o2, o5;
        int l1, l2, l5;
        Dack = 1'b1;
        load_key(K_B, 128'h00000000000000000000000affffffff, 1'b1);
        run_block(P_C1, o1, o2, o5, l1, l2, l5);
        n_total++; if (u1.r_ctr !== 128'h00000000000000000000000a00000000)
            $display("FAIL ctr_wrap: got %h want 00000000000000000000000a00000000", u1.r_ctr); else n_pass++;
        n_total++; if (l1 !== 10) $display("FAIL ctr_wrap_lat: got %0d want 10", l1); else n_pass++;
    endtask

    task automatic test_krin_drin;
        Key  = K_A;
        Iv   = 128'd0;
        Mode = 1'b0;
        Din  = P_A;
        Krin = 1'b1;
        Drin = 1'b1;
        tick();
        Krin = 1'b0;
        Drin = 1'b0;
        n_total++; if (bsy1 !== 1'b0) $display("FAIL krin_drin_bsy: got %b want 0", bsy1); else n_pass++;
        n_total++; if (u1.r_k0 !== K_A) $display("FAIL krin_drin_key: got %h want %h", u1.r_k0, K_A); else n_pass++;
        n_total++; if (u1.r_mode !== 1'b0) $display("FAIL krin_drin_mode: got %b want 0", u1.r_mode); else n_pass++;
        tick();
        n_total++; if ({bsy1, drout1} !== 2'b00) $display("FAIL krin_drin_idle: got %b want 00", {bsy1, drout1}); else n_pass++;
    endtask

    task automatic test_back_pressure;
        int lat;
        lat  = 0;
        Dack = 1'b0;
        Din  = P_A;
        Drin = 1'b1;
        tick();
        Drin = 1'b0;
        for (int n = 1; n <= 14 && lat == 0; n++) begin
            tick();
            if (drout1) lat = n;
        end
        n_total++; if (lat !== 10) $display("FAIL bp_latency: got %0d want 10", lat); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            Din  = P_B;
            Drin = (i == 1);
            tick();
            n_total++; if ({drout1, bsy1} !== 2'b11) $display("FAIL bp_hold_flags%0d: got %b want 11", i, {drout1, bsy1}); else n_pass++;
            n_total++; if (dout1 !== C_A) $display("FAIL bp_hold_dout%0d: got %h want %h", i, dout1, C_A); else n_pass++;
        end
        Drin = 1'b0;
        Dack = 1'b1;
        tick();
        n_total++; if ({drout1, bsy1} !== 2'b00) $display("FAIL bp_release_flags: got %b want 00", {drout1, bsy1}); else n_pass++;
        n_total++; if (dout1 !== C_A) $display("FAIL bp_release_dout: got %h want %h", dout1, C_A); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run;
        Dack = 1'b0;
        Din  = P_B;
        Drin = 1'b1;
        tick();
        Drin = 1'b0;
        tick();
        tick();
        n_total++; if (bsy1 !== 1'b1) $display("FAIL midrun_busy: got %b want 1", bsy1); else n_pass++;
        Reset = 1'b1;
        #1;
        n_total++; if (dout1 !== 128'd0) $display("FAIL midrun_dout: got %h want 0", dout1); else n_pass++;
        n_total++; if ({drout1, bsy1, drout5, bsy5} !== 4'b0000)
            $display("FAIL midrun_flags: got %b want 0000", {drout1, bsy1, drout5, bsy5}); else n_pass++;
        n_total++; if (u1.r_state !== 2'd0) $display("FAIL midrun_state: got %0d want 0", u1.r_state); else n_pass++;
        n_total++; if ({u1.r_k0, u1.r_ctr} !== 256'd0) $display("FAIL midrun_key_ctr: got %h want 0", {u1.r_k0, u1.r_ctr}); else n_pass++;
        #3 Reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_key;
        logic [127:0] o1, o2, o5;
        int l1, l2, l5;
        Dack = 1'b1;
        run_block(128'd0, o1, o2, o5, l1, l2, l5);
        n_total++; if (o1 !== C_ZERO) $display("FAIL zero_key_rpc1: got %h want %h", o1, C_ZERO); else n_pass++;
        n_total++; if (o5 !== C_ZERO) $display("FAIL zero_key_rpc5: got %h want %h", o5, C_ZERO); else n_pass++;
    endtask

    initial begin
        Reset = 1'b1;
        Key   = 128'd0;
        Iv    = 128'd0;
        Din   = 128'd0;
        Mode  = 1'b0;
        Krin  = 1'b0;
        Drin  = 1'b0;
        Dack  = 1'b0;
        test_reset();
        test_ecb();
        test_ctr();
        test_ctr_wrap();
        test_krin_drin();
        test_back_pressure();
        test_reset_mid_run();
        test_zero_key();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
